// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM encoding, default widths and the interrupt-controller register map.
package apb_pkg;

  localparam int unsigned ADDR_W_DEF  = 32;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  // Interrupt-controller register offsets
  localparam int unsigned IRQC_STATUS   = 1;
  localparam int unsigned IRQC_CLEAR    = 2;
  localparam int unsigned IRQC_MASK     = 3;
  localparam int unsigned IRQC_PRIO_THR = 4;
  localparam int unsigned IRQC_IRQ0     = 5;
  localparam int unsigned IRQC_IRQ1     = 6;
  localparam int unsigned IRQC_IRQ2     = 7;
  localparam int unsigned IRQC_IRQ3     = 8;

  // Counter width able to hold 0..max_val, never narrower than one bit
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val == 0) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts un-ready ACCESS cycles and flags the cycle whose stall would reach the timeout limit.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic pclk_i,
  input  logic rst_n_i,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
  localparam int unsigned LAST  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && (count_q != CNT_W'(TIMEOUT_CYCLES))) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // One more stalled cycle brings the count to TIMEOUT_CYCLES; disabled when the limit is 0
  assign expired_c = (TIMEOUT_CYCLES != 0) && (count_q == CNT_W'(LAST));

endmodule

// File: rtl/apb_master_ctrl.sv
// APB requester: command stream in, SETUP/ACCESS transfer on APB, response stream out.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic              pclk_i,
  input  logic              rst_n_i,
  input  logic              enable_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic              busy_o,
  output logic              psel_o,
  output logic              penable_o,
  output logic              pwrite_o,
  output logic [ADDR_W-1:0] paddr_o,
  output logic [DATA_W-1:0] pwdata_o,
  input  logic [DATA_W-1:0] prdata_i,
  input  logic              pready_i,
  input  logic              pslverr_i
);

  apb_state_e state_q, state_d;
  logic       idle_q;
  logic       load_cmd, cap_done, cap_abort, wait_en, timer_clear, timer_expired;

  // idle_q stays low in the first cycle after reset so cmd_ready_o is 0 while in reset
  assign cmd_ready_o = idle_q & enable_i;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .pclk_i   (pclk_i),
    .rst_n_i  (rst_n_i),
    .clear    (timer_clear),
    .enable   (wait_en),
    .expired_c(timer_expired)
  );

  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    load_cmd    = 1'b0;
    cap_done    = 1'b0;
    cap_abort   = 1'b0;
    wait_en     = 1'b0;
    timer_clear = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          load_cmd    = 1'b1;
          timer_clear = 1'b1;
          state_d     = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        // Completion takes priority over an expiring timeout
        if (pready_i) begin
          cap_done = 1'b1;
          state_d  = ST_RESP;
        end else begin
          wait_en = 1'b1;
          if (timer_expired) begin
            cap_abort = 1'b1;
            state_d   = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control outputs are registered decodes of the next state
  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      idle_q      <= 1'b0;
      busy_o      <= 1'b0;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      rsp_valid_o <= 1'b0;
    end else begin
      idle_q      <= (state_d == ST_IDLE);
      busy_o      <= (state_d != ST_IDLE);
      psel_o      <= (state_d == ST_SETUP) || (state_d == ST_ACCESS);
      penable_o   <= (state_d == ST_ACCESS);
      rsp_valid_o <= (state_d == ST_RESP);
    end
  end

  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pwrite_o <= 1'b0;
      paddr_o  <= '0;
      pwdata_o <= '0;
    end else if (load_cmd) begin
      pwrite_o <= cmd_write_i;
      paddr_o  <= cmd_addr_i;
      pwdata_o <= cmd_wdata_i;
    end
  end

  always_ff @(posedge pclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      rsp_timeout_o <= 1'b0;
    end else if (cap_done) begin
      rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
      rsp_err_o     <= pslverr_i;
      rsp_timeout_o <= 1'b0;
    end else if (cap_abort) begin
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b1;
      rsp_timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Self-checking bench for apb_master_ctrl with a small interrupt-controller slave model.
module tb_apb_master_ctrl;
  import apb_pkg::*;

  localparam int unsigned TO = 4;

  logic        pclk_i = 1'b0;
  logic        rst_n_i;
  logic        enable_i, cmd_valid_i, cmd_ready_o, cmd_write_i;
  logic [31:0] cmd_addr_i, cmd_wdata_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o, rsp_timeout_o, busy_o;
  logic        psel_o, penable_o, pwrite_o;
  logic [31:0] paddr_o, pwdata_o, prdata_i;
  logic        pready_i, pslverr_i;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        tmo;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          hs_cyc = 0;
  logic [31:0] regs[0:15];

  apb_master_ctrl #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .pclk_i(pclk_i), .rst_n_i(rst_n_i), .enable_i(enable_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .prdata_i(prdata_i),
    .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 pclk_i = ~pclk_i;
  always @(posedge pclk_i) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, cycles=%0d required <20000", cyc);
    $fatal(1);
  end

  function automatic logic [31:0] slave_read(input logic [31:0] a);
    return regs[a[3:0]];
  endfunction

  // CLEAR is write-one-to-clear on STATUS; other offsets are plain storage
  task automatic slave_write(input logic [31:0] a, input logic [31:0] d);
    if (a == 32'(IRQC_CLEAR)) regs[IRQC_STATUS] = regs[IRQC_STATUS] & ~d;
    else regs[a[3:0]] = d;
  endtask

  // Runs one command end to end; caller is at a negedge and returns at the IDLE negedge
  task automatic run_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input logic slverr, input int hold,
                          output logic [31:0] rd);
    exp_t e;
    int   n;
    logic tmo;
    rd = '0;
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr; cmd_wdata_i = wdata;
    rsp_ready_i = 1'b1;
    n = 0;
    while (!cmd_ready_o && n < 20) begin
      @(negedge pclk_i);
      n++;
    end
    checks++;
    if (cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL accept addr=%0h cmd_ready=%b required 1", addr, cmd_ready_o);
      cmd_valid_i = 1'b0;
      return;
    end
    hs_cyc = cyc;
    tmo = (waits >= int'(TO));
    e.rdata = (wr || tmo) ? 32'h0 : slave_read(addr);
    e.err   = tmo | slverr;
    e.tmo   = tmo;
    sb.push_back(e);
    @(negedge pclk_i);
    cmd_valid_i = 1'b0;
    checks++;
    if ({psel_o, penable_o, cmd_ready_o, busy_o} !== 4'b1001 || paddr_o !== addr) begin
      errors++;
      $display("FAIL setup_phase sel/en/rdy/busy=%b paddr=%0h required 1001 paddr=%0h",
               {psel_o, penable_o, cmd_ready_o, busy_o}, paddr_o, addr);
    end
    for (int i = 0; i <= waits && i < int'(TO); i++) begin
      @(negedge pclk_i);
      checks++;
      if ({psel_o, penable_o} !== 2'b11 || paddr_o !== addr || pwrite_o !== wr ||
          (wr && pwdata_o !== wdata)) begin
        errors++;
        $display("FAIL access_phase cyc%0d sel/en=%b addr=%0h wr=%b wdata=%0h required 11 %0h %b %0h",
                 i, {psel_o, penable_o}, paddr_o, pwrite_o, pwdata_o, addr, wr, wdata);
      end
      pready_i  = (i == waits);
      pslverr_i = slverr && (i == waits);
      prdata_i  = slave_read(paddr_o);
      if (i == waits && pwrite_o) slave_write(paddr_o, pwdata_o);
    end
    @(negedge pclk_i);
    pready_i = 1'b0; pslverr_i = 1'b0;
    checks++;
    if ({psel_o, penable_o, rsp_valid_o} !== 3'b001) begin
      errors++;
      $display("FAIL resp_phase sel/en/valid=%b required 001", {psel_o, penable_o, rsp_valid_o});
    end
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty size=0 required >0");
    end else begin
      e = sb.pop_front();
      rd = rsp_rdata_o;
      if (rsp_rdata_o !== e.rdata || rsp_err_o !== e.err || rsp_timeout_o !== e.tmo) begin
        errors++;
        $display("FAIL rsp addr=%0h rdata=%0h err=%b tmo=%b required rdata=%0h err=%b tmo=%b",
                 addr, rsp_rdata_o, rsp_err_o, rsp_timeout_o, e.rdata, e.err, e.tmo);
      end
    end
    rsp_ready_i = (hold == 0);
    for (int k = 0; k < hold; k++) begin
      @(negedge pclk_i);
      checks++;
      if (rsp_valid_o !== 1'b1 || cmd_ready_o !== 1'b0 || rsp_rdata_o !== e.rdata ||
          rsp_err_o !== e.err || rsp_timeout_o !== e.tmo) begin
        errors++;
        $display("FAIL rsp_hold k=%0d valid=%b rdy=%b rdata=%0h err=%b required 1 0 %0h %b",
                 k, rsp_valid_o, cmd_ready_o, rsp_rdata_o, rsp_err_o, e.rdata, e.err);
      end
      rsp_ready_i = (k == hold - 1);
    end
    @(negedge pclk_i);
    checks++;
    if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL post_rsp busy=%b valid=%b required 0 0", busy_o, rsp_valid_o);
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    #1;
    checks++;
    if ({cmd_ready_o, rsp_valid_o, busy_o, psel_o, penable_o, pwrite_o, rsp_err_o,
         rsp_timeout_o} !== 8'h00 || paddr_o !== 0 || pwdata_o !== 0 || rsp_rdata_o !== 0) begin
      errors++;
      $display("FAIL reset_outputs rdy=%b valid=%b busy=%b sel=%b en=%b required all 0",
               cmd_ready_o, rsp_valid_o, busy_o, psel_o, penable_o);
    end
    repeat (2) @(negedge pclk_i);
    rst_n_i = 1'b1;
    @(negedge pclk_i);
    checks++;
    if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release rdy=%b busy=%b required 1 0", cmd_ready_o, busy_o);
    end
  endtask

  task automatic test_write_nowait();
    logic [31:0] rd;
    run_xfer(1'b1, 32'(IRQC_MASK), 32'hF, 0, 1'b0, 0, rd);
  endtask

  task automatic test_read_waits();
    logic [31:0] rd;
    run_xfer(1'b0, 32'(IRQC_STATUS), 32'h0, 3, 1'b0, 0, rd);
    checks++;
    if (rd !== 32'h5) begin
      errors++;
      $display("FAIL read_waits rdata=%0h required 5", rd);
    end
  endtask

  task automatic test_slverr();
    logic [31:0] rd;
    run_xfer(1'b0, 32'd9, 32'h0, 0, 1'b1, 0, rd);
  endtask

  task automatic test_timeout();
    logic [31:0] rd;
    run_xfer(1'b0, 32'(IRQC_PRIO_THR), 32'h0, 10, 1'b0, 0, rd);
  endtask

  task automatic test_backpressure_enable();
    logic [31:0] rd;
    run_xfer(1'b0, 32'(IRQC_IRQ0), 32'h0, 1, 1'b0, 5, rd);
    enable_i = 1'b0;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'(IRQC_IRQ1);
    for (int k = 0; k < 3; k++) begin
      @(negedge pclk_i);
      checks++;
      if (cmd_ready_o !== 1'b0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL enable_block k=%0d rdy=%b busy=%b required 0 0", k, cmd_ready_o, busy_o);
      end
    end
    enable_i = 1'b1;
    run_xfer(1'b0, 32'(IRQC_IRQ1), 32'h0, 0, 1'b0, 0, rd);
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    int          first;
    run_xfer(1'b1, 32'(IRQC_IRQ2), 32'hA5A5_0001, 0, 1'b0, 0, rd);
    first = hs_cyc;
    run_xfer(1'b0, 32'(IRQC_IRQ2), 32'h0, 0, 1'b0, 0, rd);
    checks++;
    if (hs_cyc - first !== 4 || rd !== 32'hA5A5_0001) begin
      errors++;
      $display("FAIL back_to_back spacing=%0d rdata=%0h required 4 a5a50001", hs_cyc - first, rd);
    end
  endtask

  task automatic test_reset_mid();
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 32'(IRQC_IRQ3);
    @(negedge pclk_i);
    cmd_valid_i = 1'b0;
    @(negedge pclk_i);
    pready_i = 1'b0;
    checks++;
    if ({psel_o, penable_o} !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid_pre sel/en=%b required 11", {psel_o, penable_o});
    end
    #2 rst_n_i = 1'b0;
    #1;
    checks++;
    if ({psel_o, penable_o, busy_o, rsp_valid_o} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_async sel/en/busy/valid=%b required 0000",
               {psel_o, penable_o, busy_o, rsp_valid_o});
    end
    @(negedge pclk_i);
    rst_n_i = 1'b1;
    repeat (2) @(negedge pclk_i);
    checks++;
    if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_after busy=%b valid=%b rdy=%b required 0 0 1",
               busy_o, rsp_valid_o, cmd_ready_o);
    end
    enable_i = 1'b0;
    #1;
    checks++;
    if (cmd_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_enable rdy=%b required 0", cmd_ready_o);
    end
    enable_i = 1'b1;
    @(negedge pclk_i);
  endtask

  task automatic test_system();
    logic [31:0] rd;
    regs[IRQC_STATUS] = 32'h5;
    run_xfer(1'b1, 32'(IRQC_MASK), 32'hF, 0, 1'b0, 0, rd);
    run_xfer(1'b1, 32'(IRQC_CLEAR), 32'h1, 1, 1'b0, 0, rd);
    run_xfer(1'b0, 32'(IRQC_STATUS), 32'h0, 0, 1'b0, 0, rd);
    checks++;
    if (rd !== 32'h4 || regs[IRQC_MASK] !== 32'hF) begin
      errors++;
      $display("FAIL system_status status=%0h mask=%0h required 4 f", rd, regs[IRQC_MASK]);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'h1000_0000 + 32'(i);
    regs[IRQC_STATUS] = 32'h5;
    enable_i = 1'b1; cmd_valid_i = 1'b0; cmd_write_i = 1'b0;
    cmd_addr_i = '0; cmd_wdata_i = '0; rsp_ready_i = 1'b1;
    prdata_i = '0; pready_i = 1'b0; pslverr_i = 1'b0;
    @(negedge pclk_i);
    test_reset();
    test_write_nowait();
    test_read_waits();
    test_slverr();
    test_timeout();
    test_backpressure_enable();
    test_back_to_back();
    test_reset_mid();
    test_system();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover size=%0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
